// File: rtl/div_share_ctrl_pkg.sv
// div_share_ctrl_pkg: shared FSM encoding and defaults for the shared-divider sequencer.
package div_share_ctrl_pkg;
  localparam int DEF_W = 16;
  localparam int DEF_NREQ = 4;
  localparam logic [63:0] DIV0_Q = '1;
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT, S_RESP} state_t;
endpackage

// File: rtl/div_share_ctrl_rr_arbiter.sv
// rr_arbiter: combinational round-robin pick of the first requester at or after ptr.
module rr_arbiter
  import div_share_ctrl_pkg::*;
#(
  parameter int NREQ = DEF_NREQ,
  parameter int IDW = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  id,
  output logic            any
);
  int j;
  always_comb begin
    gnt = '0;
    id = '0;
    any = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = int'(ptr) + k;
      j = (j >= NREQ) ? j - NREQ : j;
      if (!any && req[j]) begin
        any = 1'b1;
        gnt[j] = 1'b1;
        id = IDW'(j);
      end
    end
  end
endmodule

// File: rtl/div_share_ctrl.sv
// div_share_ctrl: round-robin sequencer sharing one multicycle divider among NREQ requesters.
module div_share_ctrl
  import div_share_ctrl_pkg::*;
#(
  parameter int W = DEF_W,
  parameter int NREQ = DEF_NREQ,
  parameter int IDW = $clog2(NREQ),
  parameter int TMO = W + 8
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [NREQ-1:0] req_valid,
  input  logic [NREQ*W-1:0] req_dividend,
  input  logic [NREQ*W-1:0] req_divisor,
  output logic [NREQ-1:0] req_ready,
  output logic            rsp_valid,
  output logic [IDW-1:0]  rsp_id,
  output logic [W-1:0]    rsp_quotient,
  output logic [W-1:0]    rsp_remainder,
  output logic            rsp_err,
  output logic [W-1:0]    div_dividend,
  output logic [W-1:0]    div_divisor,
  output logic            div_init,
  output logic            div_rst,
  input  logic [W-1:0]    div_quotient,
  input  logic [W-1:0]    div_remainder,
  input  logic            div_valid,
  input  logic            div_busy
);
  localparam int CW = $clog2(TMO + 1);
  state_t state, state_nx;
  logic [IDW-1:0] rr_ptr, gid, id_q;
  logic [NREQ-1:0] gnt;
  logic [W-1:0] a_q, b_q, sel_a, sel_b;
  logic [CW-1:0] cnt;
  logic [1:0] rst_sr;
  logic tmo_rst, any, can_grant, acc, div0, tmo_hit;
  rr_arbiter #(.NREQ(NREQ), .IDW(IDW)) u_arb (
    .req(req_valid),
    .ptr(rr_ptr),
    .gnt(gnt),
    .id(gid),
    .any(any)
  );
  // rst_sr keeps the divider flushed for two edges after reset release
  always_comb begin
    sel_a = req_dividend[int'(gid)*W +: W];
    sel_b = req_divisor[int'(gid)*W +: W];
    div0 = sel_b == '0;
    can_grant = state == S_IDLE && !rst_sr[1];
    req_ready = can_grant ? gnt : '0;
    acc = can_grant && any;
    tmo_hit = state == S_WAIT && !div_valid && cnt == CW'(TMO - 1);
    div_init = state == S_LAUNCH && !div_busy;
    rsp_valid = state == S_RESP;
    div_rst = rst_sr[1] | tmo_rst;
    div_dividend = a_q;
    div_divisor = b_q;
  end
  always_comb begin
    state_nx = state;
    case (state)
      S_IDLE:   state_nx = acc ? (div0 ? S_RESP : S_LAUNCH) : S_IDLE;
      S_LAUNCH: state_nx = div_busy ? S_LAUNCH : S_WAIT;
      S_WAIT:   state_nx = (div_valid || tmo_hit) ? S_RESP : S_WAIT;
      default:  state_nx = S_IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= S_IDLE;
    else state <= state_nx;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rr_ptr <= '0;
      id_q <= '0;
      a_q <= '0;
      b_q <= '0;
      cnt <= '0;
      rst_sr <= 2'b11;
      tmo_rst <= 1'b0;
      rsp_id <= '0;
      rsp_quotient <= '0;
      rsp_remainder <= '0;
      rsp_err <= 1'b0;
    end else begin
      rst_sr <= {rst_sr[0], 1'b0};
      tmo_rst <= tmo_hit;
      cnt <= (state == S_WAIT) ? cnt + 1'b1 : '0;
      if (acc) begin
        a_q <= sel_a;
        b_q <= sel_b;
        id_q <= gid;
      end
      if (acc && div0) begin
        rsp_id <= gid;
        rsp_quotient <= DIV0_Q[W-1:0];
        rsp_remainder <= sel_a;
        rsp_err <= 1'b1;
      end
      if (state == S_WAIT && div_valid) begin
        rsp_id <= id_q;
        rsp_quotient <= div_quotient;
        rsp_remainder <= div_remainder;
        rsp_err <= 1'b0;
      end
      if (tmo_hit) begin
        rsp_id <= id_q;
        rsp_quotient <= '0;
        rsp_remainder <= '0;
        rsp_err <= 1'b1;
      end
      if (state == S_RESP) rr_ptr <= (id_q == IDW'(NREQ - 1)) ? '0 : id_q + 1'b1;
    end
  end
endmodule

// File: tb/tb_div_share_ctrl.sv
// tb_div_share_ctrl: directed and random checks of the shared-divider sequencer against a transaction-level model.
module tb_div_share_ctrl;
  localparam int W = 16;
  localparam int NREQ = 4;
  localparam int IDW = 2;
  localparam int TMO = W + 8;
  typedef struct {int id; logic [W-1:0] q; logic [W-1:0] r; logic err;} exp_t;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*W-1:0] req_dividend = '0;
  logic [NREQ*W-1:0] req_divisor = '0;
  logic [NREQ-1:0] req_ready;
  logic rsp_valid, rsp_err, div_init, div_rst;
  logic [IDW-1:0] rsp_id;
  logic [W-1:0] rsp_quotient, rsp_remainder, div_dividend, div_divisor;
  logic [W-1:0] div_quotient, div_remainder;
  logic div_valid, div_busy;
  always #5 clk = ~clk;
  div_share_ctrl #(.W(W), .NREQ(NREQ), .IDW(IDW), .TMO(TMO)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_dividend(req_dividend), .req_divisor(req_divisor),
    .req_ready(req_ready),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_quotient(rsp_quotient),
    .rsp_remainder(rsp_remainder), .rsp_err(rsp_err),
    .div_dividend(div_dividend), .div_divisor(div_divisor), .div_init(div_init),
    .div_rst(div_rst), .div_quotient(div_quotient), .div_remainder(div_remainder),
    .div_valid(div_valid), .div_busy(div_busy)
  );
  // behavioural divider: W cycles per division; stuck never finishes
  logic stuck = 1'b0;
  logic [W-1:0] d_a, d_b;
  int d_cnt;
  always @(posedge clk) begin
    if (div_rst) begin
      div_busy <= 1'b0;
      div_valid <= 1'b0;
      d_cnt <= 0;
    end else begin
      div_valid <= 1'b0;
      if (div_init && !div_busy) begin
        div_busy <= 1'b1;
        d_cnt <= W;
        d_a <= div_dividend;
        d_b <= div_divisor;
      end else if (div_busy && !stuck) begin
        if (d_cnt == 1) begin
          div_busy <= 1'b0;
          div_valid <= 1'b1;
          div_quotient <= d_a / d_b;
          div_remainder <= d_a % d_b;
        end else d_cnt <= d_cnt - 1;
      end
    end
  end
  int total = 0, bad = 0;
  int cyc = 0, m_ptr = 0;
  int n_init = 0, n_rsp = 0, n_rst = 0;
  int acc_cyc = 0, init_cyc = 0, rsp_cyc = 0, dv_cyc = 0;
  logic [NREQ-1:0] vm = '0;
  logic [W-1:0] ta[NREQ], td[NREQ];
  int left[NREQ];
  bit rnd = 1'b0;
  exp_t exp_q[$];
  int log_q[$];
  int last_id;
  logic [W-1:0] last_q, last_r;
  logic last_err;
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  function automatic int exp_grant(input logic [NREQ-1:0] m, input int p);
    for (int k = 0; k < NREQ; k++) if (m[(p + k) % NREQ]) return (p + k) % NREQ;
    return -1;
  endfunction
  function automatic logic [W-1:0] rand_div();
    return ($urandom_range(0, 4) == 0) ? '0 : W'($urandom_range(1, 300));
  endfunction
  task automatic set_req(input int i, input int a, input int b, input int n);
    ta[i] = W'(a);
    td[i] = W'(b);
    left[i] = n;
    vm[i] = n > 0;
  endtask
  task automatic step();
    int g;
    exp_t e;
    @(negedge clk);
    cyc++;
    req_valid = vm;
    for (int i = 0; i < NREQ; i++) begin
      req_dividend[i*W +: W] = ta[i];
      req_divisor[i*W +: W] = td[i];
    end
    #1;
    if (div_init) begin n_init++; init_cyc = cyc; end
    if (div_rst) n_rst++;
    if (div_valid) dv_cyc = cyc;
    g = exp_grant(req_valid, m_ptr);
    if (req_ready != '0 || (exp_q.size() == 0 && g >= 0 && !div_rst)) begin
      chk("grant", 32'(req_ready), g >= 0 ? 32'(1 << g) : 32'h0);
      chk("one_in_flight", exp_q.size(), 0);
    end
    if ((req_ready & req_valid) != '0 && g >= 0) begin
      acc_cyc = cyc;
      e.id = g;
      if (td[g] == '0) begin e.q = '1; e.r = ta[g]; e.err = 1'b1; end
      else if (stuck) begin e.q = '0; e.r = '0; e.err = 1'b1; end
      else begin e.q = ta[g] / td[g]; e.r = ta[g] % td[g]; e.err = 1'b0; end
      exp_q.push_back(e);
      left[g]--;
      if (left[g] <= 0) vm[g] = 1'b0;
      else if (rnd) begin ta[g] = W'($urandom); td[g] = rand_div(); end
    end
    if (rsp_valid) begin
      n_rsp++;
      rsp_cyc = cyc;
      last_id = int'(rsp_id);
      last_q = rsp_quotient;
      last_r = rsp_remainder;
      last_err = rsp_err;
      log_q.push_back(int'(rsp_id));
      chk("rsp_expected", exp_q.size() != 0, 1);
      if (exp_q.size() != 0) begin
        e = exp_q.pop_front();
        chk("rsp_id", rsp_id, e.id);
        chk("rsp_q", rsp_quotient, e.q);
        chk("rsp_r", rsp_remainder, e.r);
        chk("rsp_err", rsp_err, e.err);
        m_ptr = (e.id + 1) % NREQ;
      end
    end
  endtask
  task automatic wait_done(input int max);
    int n = 0;
    while ((vm != '0 || exp_q.size() != 0) && n < max) begin
      step();
      n++;
    end
    chk("drain", vm == '0 && exp_q.size() == 0, 1);
  endtask
  task automatic do_reset(input int n);
    rst = 1'b0;
    vm = '0;
    for (int i = 0; i < NREQ; i++) left[i] = 0;
    exp_q.delete();
    m_ptr = 0;
    req_valid = '1;
    req_dividend = '1;
    req_divisor = '1;
    repeat (n) @(negedge clk);
    #1;
    chk("rst_ready", req_ready, 0);
    chk("rst_rsp_valid", rsp_valid, 0);
    chk("rst_div_init", div_init, 0);
    chk("rst_div_rst", div_rst, 1);
    chk("rst_rsp_q", rsp_quotient, 0);
    chk("rst_rsp_err", rsp_err, 0);
    rst = 1'b1;
    @(negedge clk);
    #1;
    chk("div_rst_edge1", div_rst, 1);
    chk("ready_in_flush", req_ready, 0);
    @(negedge clk);
    req_valid = '0;
    #1;
    chk("div_rst_edge2", div_rst, 0);
  endtask
  initial begin
    int b_init, b_rsp, b_rst, n;
    for (int i = 0; i < NREQ; i++) begin ta[i] = '0; td[i] = '1; left[i] = 0; end
    #2;
    do_reset(2);
    b_init = n_init; b_rsp = n_rsp;
    set_req(0, 100, 7, 1);
    wait_done(200);
    chk("single_rsp_cnt", n_rsp - b_rsp, 1);
    chk("single_init_cnt", n_init - b_init, 1);
    chk("single_init_lat", init_cyc - acc_cyc, 1);
    chk("single_rsp_lat", rsp_cyc - dv_cyc, 1);
    chk("single_q", last_q, 14);
    chk("single_r", last_r, 2);
    chk("single_err", last_err, 0);
    chk("single_id", last_id, 0);
    do_reset(1);
    log_q.delete();
    for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 65535), $urandom_range(1, 50), 2);
    wait_done(1000);
    chk("cont_count", log_q.size(), 8);
    for (int k = 0; k < 8; k++) chk($sformatf("cont_order%0d", k), k < log_q.size() ? log_q[k] : 99, k % NREQ);
    log_q.delete();
    set_req(1, 77, 5, 1);
    wait_done(200);
    set_req(0, 300, 11, 1);
    set_req(2, 999, 10, 1);
    wait_done(400);
    chk("skip_count", log_q.size(), 3);
    chk("skip_first", log_q.size() > 1 ? log_q[1] : 99, 2);
    chk("skip_second", log_q.size() > 2 ? log_q[2] : 99, 0);
    b_init = n_init;
    set_req(1, 55, 0, 1);
    wait_done(100);
    chk("div0_lat", rsp_cyc - acc_cyc, 1);
    chk("div0_q", last_q, 16'hFFFF);
    chk("div0_r", last_r, 55);
    chk("div0_err", last_err, 1);
    chk("div0_id", last_id, 1);
    chk("div0_no_init", n_init - b_init, 0);
    stuck = 1'b1;
    b_rst = n_rst;
    set_req(3, 1000, 3, 1);
    wait_done(200);
    stuck = 1'b0;
    chk("tmo_q", last_q, 0);
    chk("tmo_r", last_r, 0);
    chk("tmo_err", last_err, 1);
    chk("tmo_lat", (rsp_cyc - acc_cyc >= TMO + 2) && (rsp_cyc - acc_cyc <= TMO + 3), 1);
    chk("tmo_div_rst", n_rst > b_rst, 1);
    rnd = 1'b1;
    repeat (3) begin
      for (int i = 0; i < NREQ; i++) set_req(i, $urandom_range(0, 65535), rand_div(), $urandom_range(0, 3));
      wait_done(3000);
    end
    rnd = 1'b0;
    set_req(0, 200, 9, 1);
    n = 0;
    while (!div_busy && n < 50) begin step(); n++; end
    chk("reached_wait", div_busy, 1);
    repeat (3) step();
    b_rsp = n_rsp;
    do_reset(1);
    repeat (5) step();
    chk("no_rsp_after_rst", n_rsp - b_rsp, 0);
    set_req(0, 9, 3, 1);
    wait_done(200);
    chk("post_rst_cnt", n_rsp - b_rsp, 1);
    chk("post_rst_q", last_q, 3);
    chk("post_rst_r", last_r, 0);
    chk("post_rst_err", last_err, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
